// File: rtl/mul_arbiter_pkg.sv
// Shared micro-architecture types for the multiplier arbiter slice.
// Message structs are built per-module from width parameters using these pieces.
package mul_arbiter_pkg;

  typedef enum logic [1:0] {
    UOP_MUL,
    UOP_MULH,
    UOP_MULHSU,
    UOP_MULHU
  } rv_uop;

  localparam int c_waddr_bits = 5;

  // Requester ID width; a single requester still needs one bit to index.
  function automatic int id_bits(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/mul_arbiter_if.sv
// Requester-side and multiplier-side val/rdy bundle of the multiplier arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface mul_arbiter_if
  import mul_arbiter_pkg::*;
#(
  parameter int p_num_req      = 2,
  parameter int p_addr_bits    = 32,
  parameter int p_data_bits    = 32,
  parameter int p_seq_num_bits = 5
) ();

  typedef struct packed {
    logic [p_addr_bits-1:0]    pc;
    logic [p_seq_num_bits-1:0] seq_num;
    logic [p_data_bits-1:0]    op1;
    logic [p_data_bits-1:0]    op2;
    logic [c_waddr_bits-1:0]   waddr;
    rv_uop                     uop;
  } t_mul_req;

  typedef struct packed {
    logic [p_addr_bits-1:0]    pc;
    logic [p_seq_num_bits-1:0] seq_num;
    logic [c_waddr_bits-1:0]   waddr;
    logic [p_data_bits-1:0]    wdata;
    logic                      wen;
  } t_mul_resp;

  logic [p_num_req-1:0] req_val;
  logic [p_num_req-1:0] req_rdy;
  t_mul_req             req_msg [p_num_req];
  logic                 unit_req_val;
  logic                 unit_req_rdy;
  t_mul_req             unit_req_msg;
  logic                 unit_resp_val;
  logic                 unit_resp_rdy;
  t_mul_resp            unit_resp_msg;
  logic [p_num_req-1:0] resp_val;
  logic [p_num_req-1:0] resp_rdy;
  t_mul_resp            resp_msg;
  logic [39:0]          trace;

  modport slave (
    input  req_val, req_msg, unit_req_rdy, unit_resp_val, unit_resp_msg, resp_rdy,
    output req_rdy, unit_req_val, unit_req_msg, unit_resp_rdy, resp_val, resp_msg, trace
  );

  modport master (
    output req_val, req_msg, unit_req_rdy, unit_resp_val, unit_resp_msg, resp_rdy,
    input  req_rdy, unit_req_val, unit_req_msg, unit_resp_rdy, resp_val, resp_msg, trace
  );

endinterface

// File: rtl/mul_arb_id_fifo.sv
// In-order FIFO of requester IDs for ops in flight in the multiplier.
// Depth must be a power of two so the pointers wrap naturally.
module mul_arb_id_fifo #(
  parameter int p_depth = 4,
  parameter int p_width = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [p_width-1:0]         push_id,
  input  logic                       pop,
  output logic [p_width-1:0]         head_id,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(p_depth):0]   count
);

  localparam int c_ptr_bits = $clog2(p_depth);

  logic [p_width-1:0]    mem [p_depth];
  logic [c_ptr_bits-1:0] head;
  logic [c_ptr_bits-1:0] tail;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_id;
  end

  assign head_id = mem[head];
  assign full    = (count == ($clog2(p_depth) + 1)'(p_depth));
  assign empty   = (count == '0);

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one multiplier among p_num_req requesters; responses are
// steered back in issue order. Optional stall counter: define MUL_ARBITER_STALL_CNT_EN.
module mul_arbiter
  import mul_arbiter_pkg::*;
#(
  parameter int p_num_req      = 2,
  parameter int p_addr_bits    = 32,
  parameter int p_data_bits    = 32,
  parameter int p_seq_num_bits = 5,
  parameter int p_max_outst    = 4
) (
  input  logic               clk,
  input  logic               rst,
  mul_arbiter_if.slave       bus
`ifdef MUL_ARBITER_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  localparam int c_id_bits  = id_bits(p_num_req);
  localparam int c_cnt_bits = $clog2(p_max_outst) + 1;
  localparam logic [c_id_bits-1:0] c_last_id = c_id_bits'(p_num_req - 1);

  typedef struct packed {
    logic [p_addr_bits-1:0]    pc;
    logic [p_seq_num_bits-1:0] seq_num;
    logic [p_data_bits-1:0]    op1;
    logic [p_data_bits-1:0]    op2;
    logic [c_waddr_bits-1:0]   waddr;
    rv_uop                     uop;
  } t_mul_req;

  logic [c_id_bits-1:0]  prio;
  logic [c_id_bits-1:0]  cand;
  logic [c_id_bits-1:0]  head_id;
  logic [c_cnt_bits-1:0] count;
  logic                  any_val;
  logic                  can_issue;
  logic                  req_fire;
  logic                  resp_fire;
  logic                  fifo_full;
  logic                  fifo_empty;
  t_mul_req              win_msg;

  // Scan downwards so the lowest offset from prio is the last (winning) match.
  always_comb begin
    cand    = prio;
    any_val = 1'b0;
    for (int k = p_num_req - 1; k >= 0; k--) begin
      logic [c_id_bits-1:0] idx;
      idx = c_id_bits'((int'(prio) + k) % p_num_req);
      if (bus.req_val[idx]) begin
        cand    = idx;
        any_val = 1'b1;
      end
    end
  end

  // A full FIFO blocks issue even when a pop lands the same cycle.
  assign can_issue         = !fifo_full;
  assign bus.unit_req_val  = rst && any_val && can_issue;
  assign win_msg           = bus.req_msg[cand];
  assign bus.unit_req_msg  = win_msg;
  assign req_fire          = bus.unit_req_val && bus.unit_req_rdy;

  always_comb begin
    bus.req_rdy       = '0;
    bus.req_rdy[cand] = rst && bus.unit_req_rdy && can_issue;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          prio <= '0;
    else if (req_fire) prio <= (cand == c_last_id) ? '0 : cand + 1'b1;
  end

  always_comb begin
    bus.resp_val          = '0;
    bus.resp_val[head_id] = rst && !fifo_empty && bus.unit_resp_val;
  end

  assign bus.unit_resp_rdy = rst && !fifo_empty && bus.resp_rdy[head_id];
  assign bus.resp_msg      = bus.unit_resp_msg;
  assign resp_fire         = bus.unit_resp_val && bus.unit_resp_rdy;

  mul_arb_id_fifo #(
    .p_depth (p_max_outst),
    .p_width (c_id_bits)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (req_fire),
    .push_id (cand),
    .pop     (resp_fire),
    .head_id (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  // Trace reads "<grant|.> <count> <head|.>".
  always_comb begin
    bus.trace = {8'h2e, 8'h20, 8'h30 + 8'(count), 8'h20, 8'h2e};
    if (req_fire)    bus.trace[39:32] = 8'h30 + 8'(cand);
    if (!fifo_empty) bus.trace[7:0]   = 8'h30 + 8'(head_id);
  end

  no_orphan_resp : assert property (@(posedge clk) disable iff (!rst)
                                    !(bus.unit_resp_val && fifo_empty))
    else $error("mul_arbiter: multiplier response with no op in flight");

`ifdef MUL_ARBITER_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt <= '0;
    else if (any_val && !req_fire && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule
